// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int INSTR_W = 16;
  localparam logic [3:0] OPC_HLT = 4'hF;
  typedef enum logic [1:0] {FETCH, DRAIN, HALT} fetch_state_e;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_plus2;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue2.sv
// fetch_queue2: 2-entry FIFO of {instr, pc_plus2}; flush wins over push.
module fetch_queue2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);
  fetch_entry_t mem_q [2];
  logic wr_q, rd_q;
  logic [1:0] cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) mem_q[wr_q] <= data_i;
      wr_q <= wr_q ^ push_i;
      rd_q <= rd_q ^ pop_i;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, req/ack fetch FSM and 2-entry instruction queue feeding IF/ID.
// Optional HLT detection (HALT state, halted output) enabled by FETCH_HLT_DETECT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        fetch_valid,
  output logic [15:0] fetch_instr,
  output logic [15:0] fetch_pc_plus2,
  output logic        halted
);
  fetch_state_e state_q, state_d;
  logic [15:0] pc_q, pc_d, addr_q;
  logic pend_q, pend_d, pop, room, take, push, hlt_word;
  logic [1:0] count;
  fetch_entry_t head, entry;
`ifdef FETCH_HLT_DETECT_EN
  assign hlt_word = imem_rdata[15:12] == OPC_HLT;
  assign halted = state_q == HALT;
`else
  assign hlt_word = 1'b0;
  assign halted = 1'b0;
`endif
  assign fetch_valid = count != 2'd0;
  assign fetch_instr = head.instr;
  assign fetch_pc_plus2 = head.pc_plus2;
  // pend_q keeps an issued request and its address frozen until the ack
  always_comb begin
    pop = fetch_valid && !stall_in;
    room = count != 2'd2 || pop;
    imem_req = rst && (pend_q || (state_q == FETCH && room));
    imem_addr = pend_q ? addr_q : pc_q;
    take = imem_req && imem_ack;
    push = take && state_q == FETCH && !redirect_valid;
    pend_d = imem_req && !imem_ack;
    entry = '{instr: imem_rdata, pc_plus2: imem_addr + 16'd2};
    pc_d = redirect_valid ? redirect_pc & 16'hFFFE : push ? pc_q + 16'd2 : pc_q;
    state_d = redirect_valid ? (pend_d ? DRAIN : FETCH) :
              state_q == DRAIN ? (take ? FETCH : DRAIN) :
              (push && hlt_word) ? HALT : state_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC & 16'hFFFE;
      addr_q <= RESET_PC & 16'hFFFE;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= imem_addr;
      pend_q <= pend_d;
    end
  fetch_queue2 u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  (entry),
    .head_o  (head),
    .count_o (count)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage (RESET_PC = 0x0010).
module tb_fetch_stage;
`ifdef FETCH_HLT_DETECT_EN
  localparam logic HLT_EN = 1'b1;
`else
  localparam logic HLT_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, stall_in = 1'b0, redirect_valid = 1'b0, imem_ack = 1'b0;
  logic [15:0] redirect_pc = '0, imem_rdata = '0;
  logic imem_req, fetch_valid, halted;
  logic [15:0] imem_addr, fetch_instr, fetch_pc_plus2;
  int n_vec = 0, n_err = 0;
  logic [31:0] sb [$];
  logic drain_m = 1'b0, p_req = 1'b0, p_ack = 1'b0;
  logic [15:0] p_addr = '0;
  logic s_req, s_valid, s_halted;
  logic [15:0] s_addr, s_instr, s_pp2;
  always #5 clk = ~clk;
  fetch_stage #(.RESET_PC(16'h0010)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .fetch_valid    (fetch_valid),
    .fetch_instr    (fetch_instr),
    .fetch_pc_plus2 (fetch_pc_plus2),
    .halted         (halted)
  );
  function automatic logic [15:0] mem(input logic [15:0] a);
    return a == 16'h0006 ? 16'hF000 : {4'h1, a[11:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // one clock: drive at negedge, sample, answer the request, update scoreboard
  task automatic step(input logic st, input logic rd, input logic [15:0] rpc, input logic ak);
    stall_in = st; redirect_valid = rd; redirect_pc = rpc; imem_ack = 1'b0;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = fetch_valid;
    s_instr = fetch_instr; s_pp2 = fetch_pc_plus2; s_halted = halted;
    imem_ack = ak && s_req;
    imem_rdata = mem(s_addr);
    if (p_req && !p_ack) begin
      chk("req_hold", {31'd0, s_req}, 32'd1);
      chk("addr_hold", {16'd0, s_addr}, {16'd0, p_addr});
    end
    chk("valid_vs_sb", {31'd0, s_valid}, {31'd0, sb.size() != 0});
    if (s_valid && sb.size() != 0) chk("head", {s_instr, s_pp2}, sb[0]);
    if (s_valid && !st && sb.size() != 0) void'(sb.pop_front());
    if (rd) sb.delete();
    if (imem_ack && !rd && !drain_m) sb.push_back({imem_rdata, s_addr + 16'd2});
    drain_m = rd ? (s_req && !imem_ack) : (drain_m && !imem_ack);
    p_req = s_req; p_ack = imem_ack; p_addr = s_addr;
    #1;
    @(negedge clk);
  endtask
  task automatic run_to(input logic [15:0] a);
    int n = 0;
    while (imem_addr !== a && n < 40) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      n++;
    end
    chk("reach_addr", {16'd0, imem_addr}, {16'd0, a});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_instr", {16'd0, fetch_instr}, 32'd0);
    chk("rst_pp2", {16'd0, fetch_pc_plus2}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("first_req", {31'd0, s_req}, 32'd1);
    chk("addr0", {16'd0, s_addr}, 32'h0010);
    chk("valid0", {31'd0, s_valid}, 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("addr1", {16'd0, s_addr}, 32'h0012);
    chk("pp2_1", {16'd0, s_pp2}, 32'h0012);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("addr2", {16'd0, s_addr}, 32'h0014);
    chk("pp2_2", {16'd0, s_pp2}, 32'h0014);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("stall_req0", {31'd0, s_req}, 32'd1);
    chk("stall_head0", {16'd0, s_pp2}, 32'h0016);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b1);
      chk("stall_req_low", {31'd0, s_req}, 32'd0);
      chk("stall_head", {16'd0, s_pp2}, 32'h0016);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      chk("release_valid", {31'd0, s_valid}, 32'd1);
      chk("release_pp2", {16'd0, s_pp2}, 32'h0016 + 32'(2 * i));
    end
    run_to(16'h0020);
    step(1'b0, 1'b1, 16'h0100, 1'b1);
    chk("redir_ack_addr", {16'd0, s_addr}, 32'h0020);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("redir_bubble", {31'd0, s_valid}, 32'd0);
    chk("redir_addr", {16'd0, s_addr}, 32'h0100);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("redir_pp2", {16'd0, s_pp2}, 32'h0102);
    step(1'b0, 1'b1, 16'h0030, 1'b1);
    run_to(16'h0040);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0200, 1'b0);
    chk("drain_redir_addr", {16'd0, s_addr}, 32'h0040);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("drain_addr", {16'd0, s_addr}, 32'h0040);
    chk("drain_valid", {31'd0, s_valid}, 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("drain_ack_addr", {16'd0, s_addr}, 32'h0040);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("after_drain_addr", {16'd0, s_addr}, 32'h0200);
    chk("after_drain_valid", {31'd0, s_valid}, 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("after_drain_pp2", {16'd0, s_pp2}, 32'h0202);
    step(1'b0, 1'b1, 16'hFFFF, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("wrap_addr", {16'd0, s_addr}, 32'hFFFE);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("wrap_pp2", {16'd0, s_pp2}, 32'h0000);
    chk("wrap_next_addr", {16'd0, s_addr}, 32'h0000);
    step(1'b0, 1'b1, 16'h0004, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("hlt_pre_addr", {16'd0, s_addr}, 32'h0004);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("hlt_addr", {16'd0, s_addr}, 32'h0006);
    chk("hlt_not_yet", {31'd0, s_halted}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      chk("halted", {31'd0, s_halted}, {31'd0, HLT_EN});
      chk("halt_req", {31'd0, s_req}, {31'd0, !HLT_EN});
    end
    step(1'b0, 1'b1, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("resume_halted", {31'd0, s_halted}, 32'd0);
    chk("resume_req", {31'd0, s_req}, 32'd1);
    chk("resume_addr", {16'd0, s_addr}, 32'h0000);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("midrst_instr", {16'd0, fetch_instr}, 32'd0);
    chk("midrst_pp2", {16'd0, fetch_pc_plus2}, 32'd0);
    sb.delete();
    drain_m = 1'b0; p_req = 1'b0; p_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("rerst_addr", {16'd0, s_addr}, 32'h0010);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("rerst_pp2", {16'd0, s_pp2}, 32'h0012);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
